// File: rtl/uart_fifo_avalon.sv
// Avalon-MM UART: runtime baud divisor, configurable frame format, TX/RX FIFOs,
// sticky error flags, maskable level interrupt and internal loopback.

module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign drop_o    = push_i & ~do_push_s;
  assign rdata_o   = mem_q[rptr_q];
  assign count_o   = count_q;

  always_comb begin
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= do_push_s ? wptr_q + {{(AW-1){1'b0}}, 1'b1} : wptr_q;
      rptr_q  <= do_pop_s ? rptr_q + {{(AW-1){1'b0}}, 1'b1} : rptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end
endmodule

module uart_fifo_avalon #(
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16,
  parameter int DEFAULT_DIVISOR = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  input  logic        rxd,
  output logic        txd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_C = CW'(FIFO_DEPTH / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    parity_bit = (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d, tick_cnt_q;
  logic [3:0]  err_q, err_d, err_set_s, err_clr_s;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, txd_q, tx_ser_q;
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic        tick_s, wr_s, rd_s, unused_ok_s;

  logic                 tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_drop_s;
  logic [DATA_BITS-1:0] tx_rdata_s;
  logic [CW-1:0]        tx_count_s;
  logic                 rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_drop_s;
  logic [RW-1:0]        rx_wdata_s, rx_rdata_s;
  logic [CW-1:0]        rx_count_s;

  state_e               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [3:0]           tx_bcnt_q, tx_bcnt_d, rx_bcnt_q, rx_bcnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic                 tx_par_q, tx_par_d, rx_pe_q, rx_pe_d;
  logic                 tx_line_s, tx_busy_s, tx_bit_end_s, tx_last_stop_s;
  logic                 rx_mid_s, rx_end_s, rx_fall_s, rx_raw_s;

  assign wr_s         = avs_chipselect & avs_write;
  assign rd_s         = avs_chipselect & avs_read;
  assign tick_s       = (tick_cnt_q == 16'd0);
  assign tx_push_s    = wr_s & (avs_address == 2'd0) & avs_byteenable[0];
  assign tx_bit_end_s = tick_s & (tx_bcnt_q == 4'd15);
  assign rx_mid_s     = tick_s & (rx_bcnt_q == 4'd7);
  assign rx_end_s     = tick_s & (rx_bcnt_q == 4'd15);
  assign rx_raw_s     = ctrl_q[2] ? tx_ser_q : rxd;
  assign rx_fall_s    = rx_prev_q & ~rx_sync2_q;
  assign unused_ok_s  = ^{avs_writedata[31:16], avs_byteenable[3:2]};

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign txd          = txd_q;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_clk), .rst_ni(reset_reset_n), .push_i(tx_push_s), .pop_i(tx_pop_s),
    .wdata_i(avs_writedata[DATA_BITS-1:0]), .rdata_o(tx_rdata_s), .count_o(tx_count_s),
    .full_o(tx_full_s), .empty_o(tx_empty_s), .drop_o(tx_drop_s)
  );

  uart_sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_clk), .rst_ni(reset_reset_n), .push_i(rx_push_s), .pop_i(rx_pop_s),
    .wdata_i(rx_wdata_s), .rdata_o(rx_rdata_s), .count_o(rx_count_s),
    .full_o(rx_full_s), .empty_o(rx_empty_s), .drop_o(rx_drop_s)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    err_clr_s = 4'b0;
    if (wr_s) begin
      case (avs_address)
        2'd1:    ctrl_d = avs_byteenable[0] ? avs_writedata[2:0] : ctrl_q;
        2'd2:    div_d = {avs_byteenable[1] ? avs_writedata[15:8] : div_q[15:8],
                          avs_byteenable[0] ? avs_writedata[7:0]  : div_q[7:0]};
        2'd3:    err_clr_s = avs_byteenable[0] ? avs_writedata[3:0] : 4'b0;
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
    err_set_s = {rx_push_s & ~rx_sync2_q, rx_push_s & rx_pe_q, rx_drop_s, tx_drop_s};
    err_d     = (err_q & ~err_clr_s) | err_set_s;
  end

  always_comb begin
    rdata_d  = 32'd0;
    rx_pop_s = 1'b0;
    if (rd_s) begin
      case (avs_address)
        2'd0: begin
          if (!rx_empty_s) begin
            rx_pop_s                = 1'b1;
            rdata_d[DATA_BITS-1:0]  = rx_rdata_s[DATA_BITS-1:0];
            rdata_d[8]              = rx_rdata_s[DATA_BITS];
            rdata_d[9]              = rx_rdata_s[DATA_BITS+1];
            rdata_d[15]             = 1'b1;
            rdata_d[31:16]          = 16'(rx_count_s);
          end else begin
            rdata_d = 32'd0;
          end
        end
        2'd1:    rdata_d = {16'(tx_count_s), 3'b0, tx_busy_s, rx_empty_s, rx_full_s,
                            tx_empty_s, tx_full_s, 5'b0, ctrl_q};
        2'd2:    rdata_d = {16'd0, div_q};
        2'd3:    rdata_d = {28'd0, err_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  always_comb begin
    case (tx_state_q)
      S_START:  tx_line_s = 1'b0;
      S_DATA:   tx_line_s = tx_shift_q[0];
      S_PARITY: tx_line_s = tx_par_q;
      S_STOP:   tx_line_s = 1'b1;
      default:  tx_line_s = 1'b1;
    endcase
    tx_busy_s      = (tx_state_q != S_IDLE);
    tx_last_stop_s = (tx_state_q == S_STOP) & tx_bit_end_s & (tx_idx_q == 3'(STOP_BITS - 1));
    // Reloading straight from the last stop bit keeps back-to-back frames gapless.
    tx_pop_s       = ~tx_empty_s & (((tx_state_q == S_IDLE) & tick_s) | tx_last_stop_s);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_bcnt_d  = (tick_s && tx_state_q != S_IDLE) ? tx_bcnt_q + 4'd1 : tx_bcnt_q;
    if (tx_pop_s) begin
      tx_state_d = S_START;
      tx_bcnt_d  = 4'd0;
      tx_idx_d   = 3'd0;
      tx_shift_d = tx_rdata_s;
      tx_par_d   = parity_bit(tx_rdata_s);
    end else if (tx_bit_end_s) begin
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_idx_d   = 3'd0;
        end
        S_DATA: begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == 3'(DATA_BITS - 1)) begin
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            tx_idx_d   = 3'd0;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
        S_PARITY: begin
          tx_state_d = S_STOP;
          tx_idx_d   = 3'd0;
        end
        S_STOP: begin
          if (tx_idx_q == 3'(STOP_BITS - 1)) begin
            tx_state_d = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end
        default: tx_state_d = S_IDLE;
      endcase
    end else begin
      tx_state_d = tx_state_q;
    end
  end

  always_comb begin
    rx_push_s  = (rx_state_q == S_STOP) & rx_mid_s;
    rx_wdata_s = {~rx_sync2_q, rx_pe_q, rx_shift_q};
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_pe_d    = rx_pe_q;
    rx_bcnt_d  = (tick_s && rx_state_q != S_IDLE) ? rx_bcnt_q + 4'd1 : rx_bcnt_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall_s) begin
          rx_state_d = S_START;
          rx_bcnt_d  = 4'd0;
          rx_pe_d    = 1'b0;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_mid_s && rx_sync2_q) begin
          rx_state_d = S_IDLE;
        end else if (rx_end_s) begin
          rx_state_d = S_DATA;
          rx_idx_d   = 3'd0;
        end else begin
          rx_state_d = S_START;
        end
      end
      S_DATA: begin
        rx_shift_d = rx_mid_s ? {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]} : rx_shift_q;
        if (rx_end_s) begin
          if (rx_idx_q == 3'(DATA_BITS - 1)) begin
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_state_d = S_DATA;
        end
      end
      S_PARITY: begin
        rx_pe_d    = rx_mid_s ? (rx_sync2_q != parity_bit(rx_shift_q)) : rx_pe_q;
        rx_state_d = rx_end_s ? S_STOP : S_PARITY;
      end
      S_STOP:  rx_state_d = rx_mid_s ? S_IDLE : S_STOP;
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_state_q <= S_IDLE;
      tx_bcnt_q  <= 4'd0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      rx_state_q <= S_IDLE;
      rx_bcnt_q  <= 4'd0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= '0;
      rx_pe_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      rx_state_q <= rx_state_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_pe_q    <= rx_pe_d;
    end
  end

  // A divisor write only lands at the next reload, so an in-flight count is never cut short.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tick_cnt_q <= 16'(DEFAULT_DIVISOR);
      div_q      <= 16'(DEFAULT_DIVISOR);
      ctrl_q     <= 3'd0;
      err_q      <= 4'd0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
      txd_q      <= 1'b1;
      tx_ser_q   <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tick_cnt_q <= tick_s ? div_q : tick_cnt_q - 16'd1;
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      irq_q      <= (ctrl_q[0] & ~rx_empty_s) | (ctrl_q[1] & (tx_count_s < HALF_C));
      txd_q      <= ctrl_q[2] ? 1'b1 : tx_line_s;
      tx_ser_q   <= tx_line_s;
      rx_sync1_q <= rx_raw_s;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end
endmodule
